cpu_boot_sequencer: RTL and testbench

- Sequences one run of t1c_riscv_cpu: holds the CPU in reset, preloads data memory through the CPU's external write port (Ext_MemWrite/Ext_WriteData/Ext_DataAdr), then releases reset.
- Watches the CPU data-bus writes for a result word and a completion flag, with a watchdog timeout.
- Sits between a host/loader source and the CPU top; replaces hand-timed testbench preload sequences.

---
 rtl/cpu_boot_sequencer.sv | 121 ++++++++++++
 tb/tb_cpu_boot_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer: holds the CPU in reset while preloading data memory, releases it,
// then watches its data-bus writes for a result word and a done flag under a watchdog.
module cpu_boot_sequencer #(
  parameter logic [31:0] RESULT_ADR     = 32'h02000004,
  parameter logic [31:0] DONE_ADR       = 32'h02000008,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic        i_ld_last,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  output logic        o_cpu_reset,
  output logic        o_ext_mem_write,
  output logic [31:0] o_ext_write_data,
  output logic [31:0] o_ext_data_adr,
  input  logic        i_cpu_mem_write,
  input  logic [31:0] i_cpu_write_data,
  input  logic [31:0] i_cpu_data_adr,
  output logic        o_busy,
  output logic [31:0] o_result,
  output logic        o_result_valid,
  output logic        o_done,
  output logic        o_timeout
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]      r_state;
  logic [3:0]      r_settle;
  logic [TO_W-1:0] r_wd;
  logic            r_cpu_reset, r_ext_we, r_result_valid, r_done, r_timeout;
  logic [31:0]     r_ext_data, r_ext_adr, r_result;

  logic w_idle, w_beat, w_cpu_wr, w_res_wr, w_done_wr, w_wd_exp;

  assign w_idle    = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);
  assign w_beat    = (r_state == S_LOAD) && i_ld_valid;
  // The CPU bus may carry garbage while the CPU is in reset, so only trust it in RUN.
  assign w_cpu_wr  = (r_state == S_RUN) && i_cpu_mem_write;
  assign w_res_wr  = w_cpu_wr && (i_cpu_data_adr == RESULT_ADR);
  assign w_done_wr = w_cpu_wr && (i_cpu_data_adr == DONE_ADR) && (i_cpu_write_data == 32'h1);
  assign w_wd_exp  = (r_state == S_RUN) && (r_wd == TO_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_settle       <= '0;
      r_wd           <= '0;
      r_cpu_reset    <= 1'b1;
      r_ext_we       <= 1'b0;
      r_ext_data     <= '0;
      r_ext_adr      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_ext_we <= w_beat;
      if (w_beat) begin
        r_ext_adr  <= i_ld_addr;
        r_ext_data <= i_ld_data;
      end
      if (w_res_wr) begin
        r_result       <= i_cpu_write_data;
        r_result_valid <= 1'b1;
      end
      if (w_idle && i_start) begin
        r_state        <= S_LOAD;
        r_done         <= 1'b0;
        r_timeout      <= 1'b0;
        r_result       <= '0;
        r_result_valid <= 1'b0;
      end else if (w_beat && i_ld_last) begin
        r_state  <= S_SETTLE;
        r_settle <= '0;
      end else if (r_state == S_SETTLE) begin
        if (r_settle == SETTLE_LAST) begin
          r_state     <= S_RUN;
          r_cpu_reset <= 1'b0;
          r_wd        <= '0;
        end else begin
          r_settle <= r_settle + 4'd1;
        end
      end else if (r_state == S_RUN) begin
        r_wd <= r_wd + 1'b1;
        if (w_done_wr) begin
          r_state     <= S_DONE;
          r_done      <= 1'b1;
          r_cpu_reset <= 1'b1;
        end else if (w_wd_exp) begin
          r_state     <= S_TIMEOUT;
          r_timeout   <= 1'b1;
          r_cpu_reset <= 1'b1;
        end
      end
    end
  end

  assign o_ld_ready       = (r_state == S_LOAD);
  assign o_busy           = (r_state == S_LOAD) || (r_state == S_SETTLE) || (r_state == S_RUN);
  assign o_cpu_reset      = r_cpu_reset;
  assign o_ext_mem_write  = r_ext_we;
  assign o_ext_write_data = r_ext_data;
  assign o_ext_data_adr   = r_ext_adr;
  assign o_result         = r_result;
  assign o_result_valid   = r_result_valid;
  assign o_done           = r_done;
  assign o_timeout        = r_timeout;
endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// tb_cpu_boot_sequencer: scoreboarded preload writes plus a behavioural CPU that runs
// sum-of-N / arithmetic-progression programs against two sequencer instances.
module tb_cpu_boot_sequencer;
  logic        clk = 0, reset = 1, start_a = 0, start_b = 0;
  logic        ld_valid = 0, ld_last = 0, cpu_mem_write = 0, sel = 0;
  logic [31:0] ld_addr = 0, ld_data = 0, cpu_write_data = 0, cpu_data_adr = 0;
  logic        ld_ready_v [2], cpu_reset_v [2], ext_we_v [2], busy_v [2];
  logic        rv_v [2], done_v [2], timeout_v [2];
  logic [31:0] ext_data_v [2], ext_adr_v [2], result_v [2];
  logic        ld_ready, cpu_reset, ext_we, busy, result_valid, done, timeout;
  logic [31:0] ext_data, ext_adr, result;
  int          n_chk = 0, n_err = 0;
  logic [63:0] q [$];
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  cpu_boot_sequencer #(.TIMEOUT_CYCLES(50)) u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(start_a), .i_ld_valid(ld_valid),
    .o_ld_ready(ld_ready_v[0]), .i_ld_last(ld_last), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .o_cpu_reset(cpu_reset_v[0]), .o_ext_mem_write(ext_we_v[0]), .o_ext_write_data(ext_data_v[0]),
    .o_ext_data_adr(ext_adr_v[0]), .i_cpu_mem_write(cpu_mem_write), .i_cpu_write_data(cpu_write_data),
    .i_cpu_data_adr(cpu_data_adr), .o_busy(busy_v[0]), .o_result(result_v[0]),
    .o_result_valid(rv_v[0]), .o_done(done_v[0]), .o_timeout(timeout_v[0]));

  cpu_boot_sequencer #(.RESULT_ADR(32'h0200000c), .DONE_ADR(32'h02000010)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_ld_valid(ld_valid),
    .o_ld_ready(ld_ready_v[1]), .i_ld_last(ld_last), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .o_cpu_reset(cpu_reset_v[1]), .o_ext_mem_write(ext_we_v[1]), .o_ext_write_data(ext_data_v[1]),
    .o_ext_data_adr(ext_adr_v[1]), .i_cpu_mem_write(cpu_mem_write), .i_cpu_write_data(cpu_write_data),
    .i_cpu_data_adr(cpu_data_adr), .o_busy(busy_v[1]), .o_result(result_v[1]),
    .o_result_valid(rv_v[1]), .o_done(done_v[1]), .o_timeout(timeout_v[1]));

  assign ld_ready     = ld_ready_v[sel];
  assign cpu_reset    = cpu_reset_v[sel];
  assign ext_we       = ext_we_v[sel];
  assign ext_data     = ext_data_v[sel];
  assign ext_adr      = ext_adr_v[sel];
  assign busy         = busy_v[sel];
  assign result       = result_v[sel];
  assign result_valid = rv_v[sel];
  assign done         = done_v[sel];
  assign timeout      = timeout_v[sel];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each ext write pulse must match the oldest accepted beat; the CPU memory image follows it.
  always @(negedge clk) begin
    if (ext_we) begin
      if (q.size() == 0) chk("extra_pulse", {31'b0, ext_we}, 32'h0);
      else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("ext_adr", ext_adr, e[63:32]);
        chk("ext_data", ext_data, e[31:0]);
        mem[ext_adr] = ext_data;
      end
    end
  end

  task automatic go(input logic s);
    sel = s;
    if (s) start_b = 1; else start_a = 1;
    tick();
    start_a = 0;
    start_b = 0;
    chk("ld_ready_after_start", ld_ready, 1);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      ld_valid = 0;
      ld_last  = (gap == 2);
      tick();
    end
    ld_valid = 1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    chk("ld_ready_beat", ld_ready, 1);
    if (ld_ready) q.push_back({a, d});
    tick();
    ld_valid = 0;
    ld_last  = 0;
  endtask

  task automatic await_run();
    int n = 0;
    cpu_mem_write  = 0;
    cpu_data_adr   = 0;
    cpu_write_data = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!cpu_reset) break;
      n++;
    end
    chk("settle_len", n, 3);
    chk("rv_at_run", result_valid, 0);
    chk("busy_run", busy, 1);
    chk("q_drained", q.size(), 0);
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    cpu_mem_write  = 1;
    cpu_data_adr   = a;
    cpu_write_data = d;
    tick();
    cpu_mem_write = 0;
  endtask

  // Behavioural CPU: mode 0 sums 1..N (N at 02000000), mode 1 gives term N of A + k*D.
  task automatic exec(input int mode, input logic [31:0] exp);
    logic [31:0] radr, dadr, res, part;
    radr = sel ? 32'h0200000c : 32'h02000004;
    dadr = sel ? 32'h02000010 : 32'h02000008;
    if (mode == 0) begin
      part = 0;
      for (int i = 1; i < int'(mem[32'h02000000]); i++) part += i;
      res = part + mem[32'h02000000];
    end else begin
      res  = mem[32'h02000000] + (mem[32'h02000008] - 1) * mem[32'h02000004];
      part = res - mem[32'h02000004];
    end
    cpu_wr(radr, part);
    cpu_wr(dadr, 32'h2);
    if (sel) start_b = 1; else start_a = 1;
    tick();
    start_a = 0;
    start_b = 0;
    @(negedge clk);
    chk("done2_ignored", busy, 1);
    chk("no_done_yet", done, 0);
    chk("start_in_run_ignored", result_valid, 1);
    chk("partial_result", result, part);
    cpu_wr(radr, res);
    cpu_wr(dadr, 32'h1);
    @(negedge clk);
    chk("done", done, 1);
    chk("cpu_reset_done", cpu_reset, 1);
    chk("timeout_clear", timeout, 0);
    chk("result", result, exp);
    chk("result_valid", result_valid, 1);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_ext_we", ext_we, 0);
    chk("rst_ext_adr", ext_adr, 0);
    chk("rst_ext_data", ext_data, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    reset = 0;
    tick();
    // sum of 1..15 with garbage result writes on the CPU bus during preload
    cpu_mem_write  = 1;
    cpu_data_adr   = 32'h02000004;
    cpu_write_data = 32'hdeadbeef;
    go(0);
    beat(32'h02000000, 15, 0, 0);
    beat(32'h02000004, 0, 0, 0);
    beat(32'h02000008, 0, 1, 0);
    await_run();
    exec(0, 120);
    // rerun from DONE with beat gaps and garbage done writes during preload
    go(0);
    chk("rerun_done_clr", done, 0);
    chk("rerun_rv_clr", result_valid, 0);
    chk("rerun_result_clr", result, 0);
    cpu_mem_write  = 1;
    cpu_data_adr   = 32'h02000008;
    cpu_write_data = 32'h1;
    beat(32'h02000000, 10, 0, 1);
    beat(32'h02000004, 0, 0, 2);
    beat(32'h02000008, 0, 1, 1);
    await_run();
    exec(0, 55);
    // async reset in the middle of LOAD
    go(0);
    beat(32'h02000000, 3, 0, 0);
    chk("ext_we_before_rst", ext_we, 1);
    reset = 1;
    #1;
    chk("rst_load_cpu_reset", cpu_reset, 1);
    chk("rst_load_ext_we", ext_we, 0);
    chk("rst_load_busy", busy, 0);
    chk("rst_load_ld_ready", ld_ready, 0);
    q.delete();
    reset = 0;
    // async reset in the middle of RUN
    go(0);
    beat(32'h02000000, 4, 0, 0);
    beat(32'h02000004, 0, 0, 0);
    beat(32'h02000008, 0, 1, 0);
    await_run();
    cpu_wr(32'h02000004, 7);
    @(negedge clk);
    chk("run_rv", result_valid, 1);
    chk("run_result", result, 7);
    reset = 1;
    #1;
    chk("rst_run_cpu_reset", cpu_reset, 1);
    chk("rst_run_rv", result_valid, 0);
    chk("rst_run_result", result, 0);
    chk("rst_run_busy", busy, 0);
    reset = 0;
    // fresh run after reset
    go(0);
    beat(32'h02000000, 4, 0, 0);
    beat(32'h02000004, 0, 0, 0);
    beat(32'h02000008, 0, 1, 0);
    await_run();
    exec(0, 10);
    // watchdog: CPU never writes the done flag
    go(0);
    beat(32'h02000008, 0, 1, 0);
    await_run();
    n = 0;
    while (!timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wd_cycles", n, 50);
    chk("wd_done", done, 0);
    chk("wd_cpu_reset", cpu_reset, 1);
    chk("wd_busy", busy, 0);
    // arithmetic progression on the second instance
    go(1);
    beat(32'h02000000, 5, 0, 0);
    beat(32'h02000004, 6, 0, 0);
    beat(32'h02000008, 15, 0, 0);
    beat(32'h0200000c, 0, 0, 0);
    beat(32'h02000010, 0, 1, 0);
    await_run();
    exec(1, 89);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
